// File: rtl/bp_pkg.sv
// Shared types and constants for the global-history branch sequencer.
package bp_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_e;

    localparam int BP_DEFAULT_DEPTH = 8;

endpackage

// File: rtl/bp_branch_queue.sv
// Circular queue of predicted directions; tag is the write index.
// Pushes and pops take effect at the next edge; head data is combinational; the caller owns full/empty gating.
module bp_branch_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic             push_dat,
    input  logic             pop_vld,
    input  logic             pop_flush,
    output logic             head_dat,
    output logic [TAG_W-1:0] wr_ptr,
    output logic [TAG_W-1:0] rd_ptr,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_W:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_vld) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + TAG_W'(1);
        end
        if (pop_vld) begin
            rd_ptr_d = rd_ptr_q + TAG_W'(1);
        end
        if (push_vld && !pop_vld) begin
            count_d = count_q + (TAG_W+1)'(1);
        end else if (pop_vld && !push_vld) begin
            count_d = count_q - (TAG_W+1)'(1);
        end
        // A flush pops the head and discards every younger entry.
        if (pop_vld && pop_flush) begin
            wr_ptr_d = rd_ptr_q + TAG_W'(1);
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;
    assign count    = count_q;
    assign full     = (count_q == (TAG_W+1)'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/gbp_branch_sequencer.sv
// Arbitrates one shared predictor between fetch predictions and in-order resolutions, squashing on mispredict.
// Response one cycle after accept; update/mispredict same cycle; resolutions win over predictions, full stalls fetch.
module gbp_branch_sequencer
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEFAULT_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req_valid,
    output logic             pred_req_ready,
    output logic             pred_rsp_valid,
    output logic             pred_rsp_taken,
    output logic [TAG_W-1:0] pred_rsp_tag,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    output logic             bp_predict_request,
    input  logic             bp_predicted_taken,
    output logic             bp_update_enable,
    output logic             bp_actual_taken,
    output logic             mispredict_valid,
    output logic [TAG_W-1:0] mispredict_tag,
    output logic [TAG_W:0]   inflight_count,
    output logic             seq_error
);

    seq_state_e       state_q, state_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic             rsp_taken_q, rsp_taken_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             seq_error_q, seq_error_d;

    logic             pred_acc;
    logic             res_acc;
    logic             pop_vld;
    logic             mispredict;
    logic             head_dat;
    logic [TAG_W-1:0] wr_ptr;
    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W:0]   count;
    logic             full;
    logic             empty;

    bp_branch_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (pred_acc),
        .push_dat  (bp_predicted_taken),
        .pop_vld   (pop_vld),
        .pop_flush (mispredict),
        .head_dat  (head_dat),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d     = state_q;
        rsp_vld_d   = 1'b0;
        rsp_taken_d = rsp_taken_q;
        rsp_tag_d   = rsp_tag_q;
        seq_error_d = seq_error_q;

        res_ready      = (state_q == ST_RUN);
        // A pending resolution blocks lookup so the predictor sees the updated history first.
        pred_req_ready = (state_q == ST_RUN) && !full && !res_valid;

        pred_acc   = pred_req_valid && pred_req_ready;
        res_acc    = res_valid && res_ready;
        pop_vld    = res_acc && !empty;
        mispredict = pop_vld && (res_taken != head_dat);

        if (pred_acc) begin
            rsp_vld_d   = 1'b1;
            rsp_taken_d = bp_predicted_taken;
            rsp_tag_d   = wr_ptr;
        end

        if (res_acc && (empty || (res_tag != rd_ptr))) begin
            seq_error_d = 1'b1;
        end

        case (state_q)
            ST_RUN:   state_d = mispredict ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rsp_vld_q   <= 1'b0;
            rsp_taken_q <= 1'b0;
            rsp_tag_q   <= '0;
            seq_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_tag_q   <= rsp_tag_d;
            seq_error_q <= seq_error_d;
        end
    end

    assign bp_predict_request = pred_acc;
    assign bp_update_enable   = pop_vld;
    assign bp_actual_taken    = res_taken;
    assign mispredict_valid   = mispredict;
    assign mispredict_tag     = res_tag;
    assign pred_rsp_valid     = rsp_vld_q;
    assign pred_rsp_taken     = rsp_taken_q;
    assign pred_rsp_tag       = rsp_tag_q;
    assign inflight_count     = count;
    assign seq_error          = seq_error_q;

endmodule

// File: doc/gbp_branch_sequencer.md
# gbp_branch_sequencer

Sequences a single `global_history` style predictor (one shared PHT/GHR with a combinational lookup port and a synchronous update port) between fetch-side prediction requests and execute-side in-order branch resolutions. It sits between fetch and the predictor, and:

- tracks up to DEPTH in-flight predicted branches in a circular branch queue;
- arbitrates the predictor's lookup and update ports each cycle;
- detects mispredictions and squashes younger in-flight branches.

## Interface
Parameters:
- DEPTH, 8, branch-queue entries; power of two, ≥2
- TAG_W, $clog2(DEPTH), tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pred_req_valid  in  1  fetch requests a prediction
- pred_req_ready  out  1  request accepted this cycle when both valid and ready are high
- pred_rsp_valid  out  1  one-cycle pulse carrying the response
- pred_rsp_taken  out  1  predicted direction
- pred_rsp_tag  out  TAG_W  queue tag assigned to the branch
- res_valid  in  1  execute resolves the oldest branch
- res_ready  out  1  resolution accepted
- res_tag  in  TAG_W  tag of the resolved branch
- res_taken  in  1  actual direction
- bp_predict_request  out  1  to predictor lookup port
- bp_predicted_taken  in  1  from predictor, combinational
- bp_update_enable  out  1  to predictor update port
- bp_actual_taken  out  1  to predictor update port
- mispredict_valid  out  1  one-cycle pulse, resolved direction ≠ predicted
- mispredict_tag  out  TAG_W  tag of the mispredicted branch
- inflight_count  out  TAG_W+1  occupied queue entries
- seq_error  out  1  sticky protocol-error flag

## Operation
- Queue entry holds the predicted bit. Tag = write-pointer index. Pointers wrap modulo DEPTH.
- State machine has two states:
  - RUN: both handshakes are live.
  - FLUSH: lasts exactly 1 cycle, then returns to RUN. Entered on a mispredict.
- res_ready = (state==RUN).
- pred_req_ready = (state==RUN) && count<DEPTH && !res_valid. A pending resolution has priority, so lookups always see the updated GHR. This creates a combinational path res_valid → pred_req_ready.
- Accepted prediction:
  - bp_predict_request=1 in the same cycle.
  - bp_predicted_taken is written to queue[wr_ptr]; wr_ptr++; count++.
- Accepted resolution:
  - bp_update_enable=1 and bp_actual_taken=res_taken in the same cycle.
  - Head entry is popped: rd_ptr++, count--.
  - If res_taken ≠ queue[rd_ptr]: pulse mispredict_valid with mispredict_tag=res_tag in the same cycle, set count=0, wr_ptr=rd_ptr+1, and enter FLUSH.
- Error cases (seq_error set; cleared only by rst):
  - Resolution with count==0: no predictor update, no pointer change.
  - res_tag ≠ rd_ptr: the resolution is still applied to the head entry.
- Predict and resolve are never accepted in the same cycle (guaranteed by pred_req_ready).

## Timing
- Reset: state=RUN, pointers=0, count=0; seq_error, pred_rsp_valid, mispredict_valid all 0. Reset mid-operation discards all in-flight entries.
- Prediction latency: pred_rsp_* is registered and valid the cycle after acceptance.
- mispredict_* and bp_update_* are combinational from the accepted resolution, so they appear in the same cycle.
- Throughput: 1 prediction per cycle when no resolution is pending. A mispredict costs 1 FLUSH cycle of zero acceptance.
- Full (count==DEPTH): predictions stall; resolutions still drain the queue.
- bp_predict_request and bp_update_enable are never high together.

## Structure
- The shared package `bp_pkg` holds:
  - the state enum (RUN, FLUSH);
  - the default DEPTH constant.
- The circular queue is a natural sub-module, `bp_branch_queue`: push, pop, clear-to-head, count, head data.
- The FSM and arbitration stay in the top-level module.

## Test plan
- Reset, then 3 predictions with the predictor returning T,N,T → rsp tags 0,1,2 with taken 1,0,1 one cycle after each accept; inflight_count=3.
- Fill all 8 entries → pred_req_ready=0 at count 8. Resolve tag 0 correctly → count 7, ready returns.
- Hold pred_req_valid and res_valid in the same cycle → only the update fires (bp_update_enable=1, bp_predict_request=0); the prediction is accepted the next cycle.
- Four in flight (predicted T,T,T,T), resolve tag 0 not-taken:
  - mispredict_valid=1, mispredict_tag=0 in the same cycle;
  - count=0;
  - one FLUSH cycle with both readies low;
  - next prediction gets tag 1.
- Resolution with the queue empty → seq_error=1, no bp_update_enable, count stays 0. Resolution with a wrong tag → seq_error=1, head popped.
- Assert rst with 5 in flight → next cycle count=0, seq_error=0, next tag=0.
- Wrap-around: 20 predict/resolve pairs → tags cycle 0..7,0..; no error.
